// File: rtl/bloom_filter_if.sv
// Request/response channel of the Bloom filter engine: one multi-hash request
// in, one hit/miss pulse out.
interface bloom_filter_if #(
    parameter int ADDR_W   = 10,
    parameter int NUM_HASH = 2
);
    logic [NUM_HASH*ADDR_W-1:0] hash_in;
    logic                       req_op;
    logic                       req_valid;
    logic                       req_ready;
    logic                       resp_valid;
    logic                       resp_hit;

    modport master (
        output hash_in, req_op, req_valid,
        input  req_ready, resp_valid, resp_hit
    );

    modport slave (
        input  hash_in, req_op, req_valid,
        output req_ready, resp_valid, resp_hit
    );
endinterface

// File: rtl/bloom_filter_engine.sv
// Bit-table Bloom filter: queries and inserts walk the hash indices one per
// cycle; a clear sweeps the table one 32-bit word per cycle.
module bloom_filter_engine #(
    parameter int                    ADDR_W     = 10,
    parameter int                    NUM_HASH   = 2,
    parameter logic [2**ADDR_W-1:0]  INIT_TABLE = ((2**ADDR_W)'(1) << 101) |
                                                  ((2**ADDR_W)'(1) << 165) |
                                                  ((2**ADDR_W)'(1) << 244) |
                                                  ((2**ADDR_W)'(1) << 471)
) (
    input  logic          clk,
    input  logic          rst_n,
    bloom_filter_if.slave bus,
    input  logic          clear_start,
    output logic          clear_done,
    output logic          busy,
    output logic [15:0]   insert_count
);
    localparam int TBL_BITS = 2**ADDR_W;
    localparam int WORDS    = TBL_BITS / 32;
    localparam int WW       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int IW       = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1;

    typedef enum logic [2:0] {IDLE, CHECK, SET, RESP, CLEAR} state_t;

    state_t                     state_q, state_d;
    logic [TBL_BITS-1:0]        table_q;
    logic [NUM_HASH*ADDR_W-1:0] hash_q;
    logic [IW-1:0]              idx_q;
    logic [WW-1:0]              word_q;
    logic                       all_set_q;
    logic                       resp_hit_q;
    logic [15:0]                count_q;

    logic [ADDR_W-1:0]          cur_addr;
    logic                       cur_bit;
    logic                       last_idx;
    logic                       last_word;
    logic                       ins_hit;

    always_comb begin
        cur_addr = '0;
        for (int i = 0; i < NUM_HASH; i++)
            if (idx_q == IW'(i)) cur_addr = hash_q[i*ADDR_W +: ADDR_W];
    end

    assign cur_bit   = table_q[cur_addr];
    assign last_idx  = (idx_q == IW'(NUM_HASH - 1));
    assign last_word = (word_q == WW'(WORDS - 1));
    // An insert only hits if every visited bit was already one, including this one.
    assign ins_hit   = all_set_q & cur_bit;

    // NOTE: every output and next state gets a default first, so no path
    // through the case can leave a latch behind.
    always_comb begin
        state_d        = state_q;
        bus.req_ready  = (state_q == IDLE) && !clear_start;
        bus.resp_valid = (state_q == RESP);
        bus.resp_hit   = resp_hit_q;
        clear_done     = (state_q == CLEAR) && last_word;
        busy           = (state_q != IDLE);
        insert_count   = count_q;
        case (state_q)
            IDLE:    if (clear_start)        state_d = CLEAR;
                     else if (bus.req_valid) state_d = bus.req_op ? SET : CHECK;
            CHECK:   if (!cur_bit || last_idx) state_d = RESP;
            SET:     if (last_idx)  state_d = RESP;
            RESP:    state_d = IDLE;
            CLEAR:   if (last_word) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values and
    // the order of statements below does not matter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            // NOTE: the table is a flop array rather than a RAM precisely so
            // that it can take its image on reset.
            table_q    <= INIT_TABLE;
            hash_q     <= '0;
            idx_q      <= '0;
            word_q     <= '0;
            all_set_q  <= 1'b1;
            resp_hit_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    idx_q     <= '0;
                    word_q    <= '0;
                    all_set_q <= 1'b1;
                    if (!clear_start && bus.req_valid) hash_q <= bus.hash_in;
                end
                CHECK: begin
                    idx_q <= idx_q + IW'(1);
                    if (!cur_bit || last_idx) resp_hit_q <= cur_bit;
                end
                SET: begin
                    table_q[cur_addr] <= 1'b1;
                    all_set_q         <= ins_hit;
                    idx_q             <= idx_q + IW'(1);
                    if (last_idx) begin
                        resp_hit_q <= ins_hit;
                        if (!ins_hit && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
                    end
                end
                CLEAR: begin
                    for (int w = 0; w < WORDS; w++)
                        if (word_q == WW'(w)) table_q[w*32 +: 32] <= '0;
                    word_q <= word_q + WW'(1);
                    if (last_word) count_q <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bloom_filter_engine.sv
// Self-checking bench: directed vector table, randomized traffic against a
// set-membership model, and hand-written clear/reset sequences.
module tb_bloom_filter_engine;
    localparam int AW  = 10;
    localparam int NH  = 2;
    localparam int AW4 = 6;
    localparam int NH4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clear_start, clear_done, busy;
    logic [15:0] insert_count;
    logic        clear_start4, clear_done4, busy4;
    logic [15:0] insert_count4;

    bloom_filter_if #(.ADDR_W(AW),  .NUM_HASH(NH))  bus  ();
    bloom_filter_if #(.ADDR_W(AW4), .NUM_HASH(NH4)) bus4 ();

    bloom_filter_engine #(.ADDR_W(AW), .NUM_HASH(NH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .clear_start(clear_start),
        .clear_done(clear_done), .busy(busy), .insert_count(insert_count));

    bloom_filter_engine #(.ADDR_W(AW4), .NUM_HASH(NH4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .clear_start(clear_start4),
        .clear_done(clear_done4), .busy(busy4), .insert_count(insert_count4));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the filter is just a set of bit positions plus a counter.
    logic [2**AW-1:0] m_tab;
    int               m_cnt;

    function automatic void model_reset();
        m_tab = '0;
        m_tab[101] = 1'b1;
        m_tab[165] = 1'b1;
        m_tab[244] = 1'b1;
        m_tab[471] = 1'b1;
        m_cnt = 0;
    endfunction

    function automatic void model_req(input logic op, input logic [AW-1:0] h0, input logic [AW-1:0] h1,
                                      output int lat, output logic hit);
        logic [AW-1:0] h[NH];
        h[0] = h0;
        h[1] = h1;
        hit  = 1'b1;
        lat  = NH + 1;
        if (!op) begin
            for (int i = 0; i < NH; i++)
                if (!m_tab[h[i]]) begin
                    hit = 1'b0;
                    lat = 2 + i;
                    break;
                end
        end else begin
            for (int i = 0; i < NH; i++) hit = hit & m_tab[h[i]];
            for (int i = 0; i < NH; i++) m_tab[h[i]] = 1'b1;
            if (!hit && m_cnt < 65535) m_cnt++;
        end
    endfunction

    // Issue one request and report the response cycle relative to acceptance.
    task automatic do_req(input logic op, input logic [AW-1:0] h0, input logic [AW-1:0] h1,
                          output int lat, output logic hit);
        @(negedge clk);
        bus.hash_in = {h1, h0}; bus.req_op = op; bus.req_valid = 1'b1;
        #1;
        if (!bus.req_ready) check("req_ready_idle", bus.req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0; bus.hash_in = ~bus.hash_in; bus.req_op = ~op;
        lat = -1; hit = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            #1;
            if (bus.resp_valid) begin lat = k; hit = bus.resp_hit; break; end
            @(negedge clk);
        end
    endtask

    task automatic do_req4(input logic op, input logic [NH4*AW4-1:0] hv, output int lat, output logic hit);
        @(negedge clk);
        bus4.hash_in = hv; bus4.req_op = op; bus4.req_valid = 1'b1;
        #1;
        if (!bus4.req_ready) check("req4_ready_idle", bus4.req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus4.req_valid = 1'b0; bus4.hash_in = ~hv;
        lat = -1; hit = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            #1;
            if (bus4.resp_valid) begin lat = k; hit = bus4.resp_hit; break; end
            @(negedge clk);
        end
    endtask

    function automatic logic [AW-1:0] pick();
        logic [AW-1:0] pool[6];
        pool = '{10'd101, 10'd165, 10'd244, 10'd471, 10'd7, 10'd900};
        case ($urandom_range(0, 2))
            0:       pick = pool[$urandom_range(0, 5)];
            1:       pick = AW'($urandom_range(0, 15));
            default: pick = AW'($urandom_range(0, 2**AW - 1));
        endcase
    endfunction

    typedef struct {
        logic          op;
        logic [AW-1:0] h0;
        logic [AW-1:0] h1;
        int            lat;
        logic          hit;
        int            cnt;
    } vec_t;

    vec_t vecs[10];
    int   lat, mlat, busy_n, done_n, done_at, resp_n;
    logic hit, mhit, op;
    logic [AW-1:0] r0, r1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 10'd101, 10'd244, 3, 1'b1, 0};
        vecs[1] = '{1'b0, 10'd100, 10'd101, 2, 1'b0, 0};
        vecs[2] = '{1'b0, 10'd101, 10'd102, 3, 1'b0, 0};
        vecs[3] = '{1'b1, 10'd7,   10'd900, 3, 1'b0, 1};
        vecs[4] = '{1'b0, 10'd7,   10'd900, 3, 1'b1, 1};
        vecs[5] = '{1'b1, 10'd7,   10'd900, 3, 1'b1, 1};
        vecs[6] = '{1'b1, 10'd5,   10'd5,   3, 1'b0, 2};
        vecs[7] = '{1'b0, 10'd5,   10'd5,   3, 1'b1, 2};
        vecs[8] = '{1'b0, 10'd6,   10'd5,   2, 1'b0, 2};
        vecs[9] = '{1'b1, 10'd165, 10'd6,   3, 1'b0, 3};

        rst_n = 1'b0; clear_start = 1'b0; clear_start4 = 1'b0;
        bus.hash_in = '0;  bus.req_op = 1'b0;  bus.req_valid = 1'b0;
        bus4.hash_in = '0; bus4.req_op = 1'b0; bus4.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_hit", bus.resp_hit, 0);
        check("rst_clear_done", clear_done, 0);
        check("rst_insert_count", insert_count, 0);
        check("rst_req_ready", bus.req_ready, 1);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 10; i++) begin
            model_req(vecs[i].op, vecs[i].h0, vecs[i].h1, mlat, mhit);
            do_req(vecs[i].op, vecs[i].h0, vecs[i].h1, lat, hit);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_hit", i), hit, vecs[i].hit);
            check($sformatf("vec%0d_cnt", i), insert_count, vecs[i].cnt);
        end

        for (int i = 0; i < 60; i++) begin
            op = 1'($urandom_range(0, 1));
            r0 = pick();
            r1 = pick();
            model_req(op, r0, r1, mlat, mhit);
            do_req(op, r0, r1, lat, hit);
            check($sformatf("rnd%0d_lat", i), lat, mlat);
            check($sformatf("rnd%0d_hit", i), hit, mhit);
            check($sformatf("rnd%0d_cnt", i), insert_count, m_cnt);
            @(negedge clk); #1;
            check($sformatf("rnd%0d_pulse", i), bus.resp_valid, 0);
            check($sformatf("rnd%0d_hold", i), bus.resp_hit, mhit);
        end

        // Clear wins over a simultaneous request and sweeps 32 words.
        @(negedge clk);
        clear_start = 1'b1; bus.req_valid = 1'b1; bus.req_op = 1'b0; bus.hash_in = {10'd244, 10'd101};
        #1;
        check("clear_prio_ready", bus.req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        clear_start = 1'b0; bus.req_valid = 1'b0;
        busy_n = 0; done_n = 0; done_at = -1; resp_n = 0;
        for (int k = 1; k <= 40; k++) begin
            #1;
            if (busy) busy_n++;
            if (clear_done) begin done_n++; if (done_at < 0) done_at = k; end
            if (bus.resp_valid) resp_n++;
            if (!busy) break;
            @(negedge clk);
        end
        check("clear_busy_cycles", busy_n, 32);
        check("clear_done_cycle", done_at, 32);
        check("clear_done_pulses", done_n, 1);
        check("clear_req_refused", resp_n, 0);
        check("clear_count_zero", insert_count, 0);
        m_tab = '0; m_cnt = 0;
        do_req(1'b0, 10'd101, 10'd244, lat, hit);
        check("post_clear_hit", hit, 0);
        check("post_clear_lat", lat, 2);

        // Reset in the middle of a CHECK.
        @(negedge clk);
        bus.hash_in = {10'd244, 10'd101}; bus.req_op = 1'b0; bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        check("rst_check_busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_check_ready", bus.req_ready, 1);
        resp_n = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.resp_valid) resp_n++;
            @(negedge clk); #1;
        end
        check("rst_check_no_resp", resp_n, 0);
        model_reset();
        do_req(1'b0, 10'd101, 10'd244, lat, hit);
        check("rst_check_init_hit", hit, 1);
        check("rst_check_init_lat", lat, 3);

        // Reset in the middle of a CLEAR.
        do_req(1'b1, 10'd7, 10'd900, lat, hit);
        check("pre_clr_rst_cnt", insert_count, 1);
        @(negedge clk);
        clear_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear_start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_clear_ready", bus.req_ready, 1);
        done_n = 0; busy_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (clear_done) done_n++;
            if (busy) busy_n++;
            @(negedge clk); #1;
        end
        check("rst_clear_no_done", done_n, 0);
        check("rst_clear_idle", busy_n, 0);
        check("rst_clear_cnt", insert_count, 0);
        model_reset();
        do_req(1'b0, 10'd165, 10'd471, lat, hit);
        check("rst_clear_init_hit", hit, 1);
        do_req(1'b0, 10'd7, 10'd900, lat, hit);
        check("rst_clear_insert_gone", hit, 0);

        // Four-hash, 64-entry instance: duplicate indices and a two-word clear.
        do_req4(1'b1, {4{6'd3}}, lat, hit);
        check("h4_ins_hit", hit, 0);
        check("h4_ins_lat", lat, 5);
        check("h4_ins_cnt", insert_count4, 1);
        do_req4(1'b0, {4{6'd3}}, lat, hit);
        check("h4_qry_hit", hit, 1);
        check("h4_qry_lat", lat, 5);
        do_req4(1'b0, {6'd3, 6'd3, 6'd4, 6'd3}, lat, hit);
        check("h4_qry_miss_hit", hit, 0);
        check("h4_qry_miss_lat", lat, 3);
        @(negedge clk);
        clear_start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear_start4 = 1'b0;
        busy_n = 0; done_at = -1;
        for (int k = 1; k <= 10; k++) begin
            #1;
            if (busy4) busy_n++;
            if (clear_done4 && done_at < 0) done_at = k;
            if (!busy4) break;
            @(negedge clk);
        end
        check("h4_clear_busy", busy_n, 2);
        check("h4_clear_done_at", done_at, 2);
        do_req4(1'b0, {4{6'd3}}, lat, hit);
        check("h4_post_clear_hit", hit, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bloom_filter_engine.md
BLOOM_FILTER_ENGINE -- requirements
Module: bloom_filter_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning table index width; table holds 2^ADDR_W bits; legal range 5..12.
REQ-002 SHALL have parameter NUM_HASH, default 2, meaning hashes per word; legal range 1..8.
REQ-003 SHALL have parameter INIT_TABLE, width 2^ADDR_W, default bits 101, 165, 244 and 471 set and all others clear, meaning the table contents loaded at reset.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 hash_in  input  NUM_HASH*ADDR_W  hash indices; hash i at bits [i*ADDR_W +: ADDR_W].
REQ-007 req_op  input  1  0 = query, 1 = insert.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  engine accepts a request this cycle.
REQ-010 clear_start  input  1  one-cycle pulse; starts table clear.
REQ-011 resp_valid  output  1  one-cycle pulse; result available.
REQ-012 resp_hit  output  1  query: all indexed bits set (word flagged bad); insert: all bits were already set before insert.
REQ-013 clear_done  output  1  one-cycle pulse at end of clear.
REQ-014 busy  output  1  state is not IDLE.
REQ-015 insert_count  output  16  number of inserts that set at least one new bit, saturating.

Function
REQ-016 SHALL implement FSM states IDLE, CHECK, SET, RESP and CLEAR, plus a hash index counter 0..NUM_HASH-1.
REQ-017 SHALL drive req_ready = (state == IDLE) && !clear_start, combinationally.
REQ-018 SHALL accept a request on the req_valid && req_ready cycle T, latch hash_in and req_op, and ignore hash_in afterwards.
REQ-019 SHALL, after an accepted query, enter CHECK and test the bit at hash i in cycle T+1+i, one index per cycle.
REQ-020 SHALL, on the first zero bit at index i, go to RESP with resp_hit=0 and pulse resp_valid in cycle T+2+i.
REQ-021 SHALL, when all NUM_HASH bits are one, pulse resp_valid with resp_hit=1 in cycle T+NUM_HASH+1.
REQ-022 SHALL, after an accepted insert, enter SET, read and set the bit at hash i in cycle T+1+i, and pulse resp_valid in cycle T+NUM_HASH+1.
REQ-023 SHALL, for an insert, set resp_hit=1 only if every bit was already one when it was visited.
REQ-024 SHALL handle duplicate indices within one request naturally: the second visit sees the bit written by the first.
REQ-025 SHALL increment insert_count when an insert response has resp_hit=0, saturating at 16'hFFFF.
REQ-026 SHALL hold resp_hit stable from the resp_valid cycle until the next resp_valid; RESP returns to IDLE after one cycle.
REQ-027 SHALL, on clear_start in IDLE, enter CLEAR and zero one 32-bit table word per cycle, words 0 to 2^ADDR_W/32-1 in ascending order.
REQ-028 SHALL pulse clear_done in the cycle the last word is zeroed, zero insert_count in that same cycle, and return to IDLE next cycle.
REQ-029 SHALL ignore clear_start outside IDLE, and SHALL NOT reload INIT_TABLE on clear.
REQ-030 SHALL give clear_start priority when clear_start and req_valid are high in the same IDLE cycle; the request is not accepted.
REQ-031 SHALL make a queried bit reflect any insert whose resp_valid occurred in an earlier cycle.

Reset
REQ-032 SHALL, while rst_n=0 at a clock edge, set state=IDLE, table=INIT_TABLE, insert_count=0, resp_valid=0, resp_hit=0, clear_done=0 and busy=0.
REQ-033 SHALL, on reset during CHECK, SET or CLEAR, abandon the operation with no resp_valid or clear_done, and assert req_ready in the first cycle after rst_n rises.

Verification
REQ-034 Reset, then query {101,244} accepted at T -> resp_valid at T+3, resp_hit=1, insert_count=0.
REQ-035 Reset, then query {100,101} at T -> resp_valid at T+2 (early exit), resp_hit=0; query {101,102} -> resp at T+3, resp_hit=0.
REQ-036 Insert {7,900} -> resp_hit=0, insert_count=1; query {7,900} -> resp_hit=1; re-insert -> resp_hit=1, insert_count stays 1.
REQ-037 clear_start and req_valid high in the same cycle -> request refused; busy for 32 cycles (ADDR_W=10); clear_done on 32nd; query {101,244} then resp_hit=0.
REQ-038 rst_n=0 during the CHECK or CLEAR cycle -> no resp_valid or clear_done; INIT_TABLE restored; req_ready=1 in the first cycle after reset.
REQ-039 With NUM_HASH=4 and ADDR_W=6, insert {3,3,3,3} -> resp_hit=0 and resp at T+5; query {3,3,3,3} -> resp_hit=1 at T+5.
